// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: transmit half of the UART.
// Sends start bit, DATA_WIDTH data bits LSB first, an optional parity bit and a
// stop bit, each lasting `prescale` clocks (8, 16 or 32).
// Optional feature macro: UART_TX_PARITY_EN builds the PARITY state and the
// parity logic; without it PAR_EN and PAR_TYP are accepted but ignored.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            prescale,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } txState_e;

  txState_e                state_q, state_d;
  logic [5:0]              bitCnt_q, bitCnt_d;
  logic [IDX_W-1:0]        bitIdx_q, bitIdx_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [5:0]              prescale_q, prescale_d;
  logic                    txOut_q, txOut_d;
  logic                    busy_q, busy_d;
  logic                    bitTick;
  logic                    prescaleLegal;

`ifdef UART_TX_PARITY_EN
  logic                    parEn_q, parEn_d;
  logic                    parBit_q, parBit_d;
`else
  logic                    unusedParity;
  assign unusedParity = PAR_EN ^ PAR_TYP;
`endif

  assign bitTick       = (bitCnt_q == (prescale_q - 6'd1));
  assign prescaleLegal = (prescale == 6'd8) || (prescale == 6'd16) || (prescale == 6'd32);

  assign TX_OUT = txOut_q;
  assign busy   = busy_q;

  // State, counters, latched frame fields and registered line outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      prescale_q <= '0;
      txOut_q    <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parEn_q    <= 1'b0;
      parBit_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      prescale_q <= prescale_d;
      txOut_q    <= txOut_d;
      busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
      parEn_q    <= parEn_d;
      parBit_q   <= parBit_d;
`endif
    end
  end

  // Next-state logic; line outputs are decoded from the next state so that
  // they appear in the same cycle the state register takes the new state.
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    prescale_d = prescale_q;
`ifdef UART_TX_PARITY_EN
    parEn_d    = parEn_q;
    parBit_d   = parBit_q;
`endif

    case (state_q)
      IDLE: begin
        bitCnt_d = '0;
        bitIdx_d = '0;
        if (Data_Valid && prescaleLegal) begin
          shift_d    = P_DATA;
          prescale_d = prescale;
`ifdef UART_TX_PARITY_EN
          parEn_d    = PAR_EN;
          parBit_d   = (^P_DATA) ^ PAR_TYP;
`endif
          state_d    = START;
        end
      end
      START: begin
        if (bitTick) begin
          bitCnt_d = '0;
          state_d  = DATA;
        end else begin
          bitCnt_d = bitCnt_q + 6'd1;
        end
      end
      DATA: begin
        if (bitTick) begin
          bitCnt_d = '0;
          if (bitIdx_q == LAST_IDX) begin
            bitIdx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d  = parEn_q ? PARITY : STOP;
`else
            state_d  = STOP;
`endif
          end else begin
            bitIdx_d = bitIdx_q + 1'b1;
            shift_d  = shift_q >> 1;
          end
        end else begin
          bitCnt_d = bitCnt_q + 6'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bitTick) begin
          bitCnt_d = '0;
          state_d  = STOP;
        end else begin
          bitCnt_d = bitCnt_q + 6'd1;
        end
      end
`endif
      STOP: begin
        if (bitTick) begin
          bitCnt_d = '0;
          state_d  = IDLE;
        end else begin
          bitCnt_d = bitCnt_q + 6'd1;
        end
      end
      default: begin
        bitCnt_d = '0;
        bitIdx_d = '0;
        state_d  = IDLE;
      end
    endcase

    txOut_d = 1'b1;
    busy_d  = 1'b1;
    case (state_d)
      IDLE:    busy_d  = 1'b0;
      START:   txOut_d = 1'b0;
      DATA:    txOut_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txOut_d = parBit_q;
`endif
      STOP:    txOut_d = 1'b1;
      default: busy_d  = 1'b0;
    endcase
  end

endmodule
